// File: rtl/datapath_gray.sv
// RGB888 -> 8-bit luma pipeline, two register stages with a downstream stall.
// Define GRAY_ROUND_EN for round-half-up; truncation is the default.
module datapath_gray (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic [23:0] data_in,
   input  logic        valid_in,
   input  logic        sof_in,
   output logic        busy_out,
   output logic [7:0]  data_out,
   output logic        valid_out,
   output logic        sof_out,
   input  logic        busy_in
);

   logic [15:0] r_prod_d, r_prod_q;
   logic [15:0] g_prod_d, g_prod_q;
   logic [15:0] b_prod_d, b_prod_q;
   logic        valid1_d, valid1_q;
   logic        sof1_d, sof1_q;
   logic [7:0]  gray_d, gray_q;
   logic        valid2_q, sof2_q;
   logic        stall;
   logic [15:0] sum;
   logic [15:0] sum_adj;

   always_comb begin
      stall    = busy_in & valid2_q;
      r_prod_d = 16'(data_in[23:16]) * 16'd77;
      g_prod_d = 16'(data_in[15:8]) * 16'd150;
      b_prod_d = 16'(data_in[7:0]) * 16'd29;
      valid1_d = valid_in;
      // sof without a valid pixel is meaningless and must not propagate
      sof1_d   = sof_in & valid_in;
      // Coefficients sum to 256, so the sum tops out at 65280 and +128 still fits.
      sum      = r_prod_q + g_prod_q + b_prod_q;
`ifdef GRAY_ROUND_EN
      sum_adj  = sum + 16'd128;
`else
      sum_adj  = sum;
`endif
      gray_d   = 8'(sum_adj >> 8);
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_prod_q <= '0;
         g_prod_q <= '0;
         b_prod_q <= '0;
         valid1_q <= 1'b0;
         sof1_q   <= 1'b0;
         gray_q   <= '0;
         valid2_q <= 1'b0;
         sof2_q   <= 1'b0;
      end else if (!stall) begin
         r_prod_q <= r_prod_d;
         g_prod_q <= g_prod_d;
         b_prod_q <= b_prod_d;
         valid1_q <= valid1_d;
         sof1_q   <= sof1_d;
         gray_q   <= gray_d;
         valid2_q <= valid1_q;
         sof2_q   <= sof1_q;
      end
   end

   assign busy_out  = stall;
   assign data_out  = gray_q;
   assign valid_out = valid2_q;
   assign sof_out   = sof2_q;

endmodule

// File: tb/tb_datapath_gray.sv
// Directed bench for datapath_gray: per-cycle vector table plus reset sequences.
// Expected gray values carry both truncated and GRAY_ROUND_EN variants.
module tb_datapath_gray;

   logic        clk = 1'b0;
   logic        rst;
   logic [23:0] data_in;
   logic        valid_in;
   logic        sof_in;
   logic        busy_out;
   logic [7:0]  data_out;
   logic        valid_out;
   logic        sof_out;
   logic        busy_in;

   int checks = 0;
   int errors = 0;

   datapath_gray dut (
      .i_clk     (clk),
      .i_rst     (rst),
      .data_in   (data_in),
      .valid_in  (valid_in),
      .sof_in    (sof_in),
      .busy_out  (busy_out),
      .data_out  (data_out),
      .valid_out (valid_out),
      .sof_out   (sof_out),
      .busy_in   (busy_in)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [23:0] din;
      logic        vin;
      logic        sin;
      logic        bin;
      logic        exp_valid;
      logic        exp_sof;
      logic        exp_busy;
      logic [7:0]  exp_trunc;
      logic [7:0]  exp_round;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic [23:0] din, input logic vin, input logic sin, input logic bin,
                      input logic ev, input logic es, input logic eb,
                      input logic [7:0] et, input logic [7:0] er);
      vec_t v;
      v.din = din; v.vin = vin; v.sin = sin; v.bin = bin;
      v.exp_valid = ev; v.exp_sof = es; v.exp_busy = eb;
      v.exp_trunc = et; v.exp_round = er;
      vecs.push_back(v);
   endtask

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [7:0] exp_d;
      rst = 1'b1; data_in = '0; valid_in = 1'b0; sof_in = 1'b0; busy_in = 1'b0;
      #50;
      chk("rst_valid", {7'd0, valid_out}, 8'd0);
      chk("rst_sof", {7'd0, sof_out}, 8'd0);
      chk("rst_data", data_out, 8'h00);
      chk("rst_busy", {7'd0, busy_out}, 8'd0);
      #50;
      rst = 1'b0;

      // Back-to-back stream
      add(24'hFFFFFF, 1, 1, 0, 0, 0, 0, 8'h00, 8'h00);
      add(24'hFFFF00, 1, 0, 0, 0, 0, 0, 8'h00, 8'h00);
      add(24'hFF0000, 1, 0, 0, 1, 1, 0, 8'hFF, 8'hFF);
      add(24'h000000, 1, 0, 0, 1, 0, 0, 8'hE2, 8'hE2);
      add(24'h0000FF, 1, 0, 0, 1, 0, 0, 8'h4C, 8'h4D);
      add(24'h00FF00, 1, 0, 0, 1, 0, 0, 8'h00, 8'h00);
      add(24'h000000, 0, 0, 0, 1, 0, 0, 8'h1C, 8'h1D);
      add(24'h000000, 0, 0, 0, 1, 0, 0, 8'h95, 8'h95);
      add(24'h000000, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00);
      // Three-cycle stall with valid output; C held by upstream until release
      add(24'hFF0000, 1, 1, 0, 0, 0, 0, 8'h00, 8'h00);
      add(24'h0000FF, 1, 0, 0, 0, 0, 0, 8'h00, 8'h00);
      add(24'h00FF00, 1, 0, 1, 1, 1, 1, 8'h4C, 8'h4D);
      add(24'h00FF00, 1, 0, 1, 1, 1, 1, 8'h4C, 8'h4D);
      add(24'h00FF00, 1, 0, 1, 1, 1, 1, 8'h4C, 8'h4D);
      add(24'h00FF00, 1, 0, 0, 1, 1, 0, 8'h4C, 8'h4D);
      add(24'h000000, 0, 0, 0, 1, 0, 0, 8'h1C, 8'h1D);
      add(24'h000000, 0, 0, 0, 1, 0, 0, 8'h95, 8'h95);
      add(24'h000000, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00);
      // Alternating valid; stray sof on bubbles must vanish
      add(24'h808080, 1, 0, 0, 0, 0, 0, 8'h00, 8'h00);
      add(24'hFFFFFF, 0, 1, 0, 0, 0, 0, 8'h00, 8'h00);
      add(24'h0000FF, 1, 0, 0, 1, 0, 0, 8'h80, 8'h80);
      add(24'hFFFFFF, 0, 1, 0, 0, 0, 0, 8'h00, 8'h00);
      add(24'hFFFF00, 1, 0, 0, 1, 0, 0, 8'h1C, 8'h1D);
      add(24'h000000, 0, 1, 0, 0, 0, 0, 8'h00, 8'h00);
      add(24'h000000, 0, 0, 0, 1, 0, 0, 8'hE2, 8'hE2);
      add(24'h000000, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00);
      // busy_in with empty pipeline: bubbles collapse, pixel reaches output then holds
      add(24'h808080, 1, 0, 1, 0, 0, 0, 8'h00, 8'h00);
      add(24'h000000, 0, 0, 1, 0, 0, 0, 8'h00, 8'h00);
      add(24'h000000, 0, 0, 1, 1, 0, 1, 8'h80, 8'h80);
      add(24'h000000, 0, 0, 1, 1, 0, 1, 8'h80, 8'h80);
      add(24'h000000, 0, 0, 0, 1, 0, 0, 8'h80, 8'h80);
      add(24'h000000, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00);

      next_cycle();
      foreach (vecs[i]) begin
         data_in  = vecs[i].din;
         valid_in = vecs[i].vin;
         sof_in   = vecs[i].sin;
         busy_in  = vecs[i].bin;
         #1;
`ifdef GRAY_ROUND_EN
         exp_d = vecs[i].exp_round;
`else
         exp_d = vecs[i].exp_trunc;
`endif
         chk($sformatf("v%0d_valid", i), {7'd0, valid_out}, {7'd0, vecs[i].exp_valid});
         chk($sformatf("v%0d_sof", i), {7'd0, sof_out}, {7'd0, vecs[i].exp_sof});
         chk($sformatf("v%0d_busy", i), {7'd0, busy_out}, {7'd0, vecs[i].exp_busy});
         if (vecs[i].exp_valid) chk($sformatf("v%0d_data", i), data_out, exp_d);
         next_cycle();
      end

      // Mid-stream asynchronous reset with two pixels in flight
      data_in = 24'hFF0000; valid_in = 1'b1; sof_in = 1'b1; busy_in = 1'b0;
      next_cycle();
      data_in = 24'h00FF00; sof_in = 1'b0;
      next_cycle();
      valid_in = 1'b0;
      #1;
      chk("pre_rst_valid", {7'd0, valid_out}, 8'd1);
      chk("pre_rst_sof", {7'd0, sof_out}, 8'd1);
      #2;
      rst = 1'b1;
      #1;
      chk("async_rst_valid", {7'd0, valid_out}, 8'd0);
      chk("async_rst_sof", {7'd0, sof_out}, 8'd0);
      chk("async_rst_data", data_out, 8'h00);
      chk("async_rst_busy", {7'd0, busy_out}, 8'd0);
      next_cycle();
      #3;
      rst = 1'b0;
      for (int k = 0; k < 4; k++) begin
         next_cycle();
         chk($sformatf("post_rst_idle%0d", k), {7'd0, valid_out}, 8'd0);
      end
      data_in = 24'h0000FF; valid_in = 1'b1;
      next_cycle();
      valid_in = 1'b0;
      chk("post_rst_lat1", {7'd0, valid_out}, 8'd0);
      next_cycle();
      chk("post_rst_lat2", {7'd0, valid_out}, 8'd1);
`ifdef GRAY_ROUND_EN
      chk("post_rst_data", data_out, 8'h1D);
`else
      chk("post_rst_data", data_out, 8'h1C);
`endif
      next_cycle();
      chk("post_rst_drain", {7'd0, valid_out}, 8'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
